// File: rtl/pwm_generator.sv
// PWM generator for an H-bridge. Ratio and direction updates take effect only
// at period boundaries. A direction reversal forces the drive low for a dead
// time before the new direction is applied.
module pwm_generator #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] active_ratio
);

  localparam int unsigned RW = 8;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
  localparam logic [RW-1:0] CNT_LAST   = RW'(254);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] cnt_q,   cnt_d;
  logic [RW-1:0] ratio_q, ratio_d;
  logic [RW-1:0] pend_q,  pend_d;
  logic [DW-1:0] dead_q,  dead_d;
  logic          dir_q,   dir_d;
  logic          first_q, first_d;
  logic          done_q,  done_d;
  logic          pwm_q,   pwm_d;

  logic tick_c;
  logic load_pt_c;

  // A period count tick, and a load point: first RUN cycle or the last tick of a period.
  assign tick_c    = (presc_q == PRESC_LAST);
  assign load_pt_c = first_q || (tick_c && (cnt_q == CNT_LAST));

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    first_d = 1'b0;
    done_d  = 1'b0;

    if (!pwm_enable) begin
      // Disable wins over everything, including a coincident load point.
      state_d = ST_OFF;
      presc_d = '0;
      cnt_d   = '0;
      ratio_d = '0;
      dead_d  = '0;
      if ((state_q == ST_OFF) && pwm_update) dir_d = pwm_direction;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          // Output is already off, so a new direction needs no dead time.
          if (pwm_update) dir_d = pwm_direction;
          state_d = ST_RUN;
          first_d = 1'b1;
          presc_d = '0;
          cnt_d   = '0;
        end
        ST_RUN: begin
          if (load_pt_c && pwm_update && (pwm_direction != dir_q)) begin
            pend_d  = pwm_ratio;
            state_d = ST_DEAD;
            dead_d  = '0;
            presc_d = '0;
            cnt_d   = '0;
          end else begin
            if (load_pt_c && pwm_update) begin
              ratio_d = pwm_ratio;
              done_d  = 1'b1;
            end
            // The entry load cycle holds the counters so the first period starts with the new ratio.
            if (!first_q) begin
              if (tick_c) begin
                presc_d = '0;
                cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + RW'(1);
              end else begin
                presc_d = presc_q + PW'(1);
              end
            end
          end
        end
        ST_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = ST_RUN;
            dir_d   = ~dir_q;
            ratio_d = pend_q;
            done_d  = 1'b1;
            dead_d  = '0;
            presc_d = '0;
            cnt_d   = '0;
          end else begin
            dead_d = dead_q + DW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Drive is computed from the next-state values so it lines up with the registered counters.
    pwm_d = (state_d == ST_RUN) && (cnt_d < ratio_d);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      presc_q <= '0;
      cnt_q   <= '0;
      ratio_q <= '0;
      pend_q  <= '0;
      dead_q  <= '0;
      dir_q   <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_done     = done_q;
  assign pwm_out      = pwm_q;
  assign dir_out      = dir_q;
  assign active_ratio = ratio_q;

endmodule
